// File: rtl/bit_serial_subtract_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the counter-sizing helper.
package bit_serial_subtract_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest counter width that can hold w-1 (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bit_serial_subtract_full_subtract.sv
// One-bit full subtractor cell: diff = a - b - borrowIn, with borrow out.
module full_subtract (
  output logic diff,
  output logic borrowOut,
  input  logic a,
  input  logic b,
  input  logic borrowIn
);

  assign diff      = a ^ b ^ borrowIn;
  assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);

endmodule

// File: rtl/bit_serial_subtract.sv
// Bit-serial subtractor: one full_subtract cell processes one bit per RUN cycle,
// LSB first, producing a - b - borrow_in after WIDTH cycles.
module bit_serial_subtract
  import bit_serial_subtract_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int             CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic fs_diff;
  logic fs_borrow;

  full_subtract u_fs (
    .diff      (fs_diff),
    .borrowOut (fs_borrow),
    .a         (a_q[0]),
    .b         (b_q[0]),
    .borrowIn  (borrow_q)
  );

  // NOTE: every *_d and output gets a default first so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          borrow_d = borrow_in;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = {fs_diff, res_q[WIDTH-1:1]};
        borrow_d = fs_borrow;
        bout_d   = fs_borrow;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done = 1'b1;
        // Accepting here gives zero-bubble back-to-back operation; the result
        // register keeps the old value until the new op's first RUN edge.
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          borrow_d = borrow_in;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: every register, operands and result included, is reset so outputs are defined and an aborted op leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign diff_out   = res_q;
  assign borrow_out = bout_q;

endmodule
